// File: rtl/aes_pkg.sv
// Shared AES byte-stream definitions: block size, byte type and the
// ShiftRows / InvShiftRows output-to-source index tables.
package aes_pkg;

  localparam int unsigned AES_BLK_BYTES = 16;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] idx_t;

  // Entry k is the source byte index that produces output byte o_k.
  localparam idx_t AES_INV_SR_IDX [AES_BLK_BYTES] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  localparam idx_t AES_FWD_SR_IDX [AES_BLK_BYTES] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

endpackage

// File: rtl/aes_inv_shiftrows_stream_if.sv
// Byte-stream handshake bundle for the ShiftRows stage: input and output
// valid/ready channels plus the end-of-block marker.
interface aes_inv_shiftrows_stream_if;
  import aes_pkg::*;

  logic  in_valid;
  logic  in_ready;
  byte_t in_data;
  logic  out_valid;
  logic  out_ready;
  byte_t out_data;
  logic  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes_byte_bank.sv
// 16x8 register bank: one synchronous write port, one combinational read port.
module aes_byte_bank
  import aes_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  idx_t  waddr,
  input  byte_t wdata,
  input  idx_t  raddr,
  output byte_t rdata
);

  byte_t mem [AES_BLK_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < AES_BLK_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aes_inv_shiftrows_stream.sv
// Byte-serial, ping-pong buffered (Inv)ShiftRows stage: a block is written
// in arrival order into one bank and read out permuted from the other.
module aes_inv_shiftrows_stream
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
)
(
  input logic                          clk,
  input logic                          rst_n,
  input logic                          sync_clr,
  aes_inv_shiftrows_stream_if.slave    io
);

  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_cnt;
  idx_t       rd_cnt;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic       in_fire;
  logic       out_fire;
  logic       wr_done;
  logic       rd_done;
  logic [1:0] we;
  idx_t       rd_idx;
  byte_t      rdata0;
  byte_t      rdata1;
  byte_t      rdata_sel;

  assign io.in_ready  = ~full[wr_bank];
  assign io.out_valid = full[rd_bank];

  // sync_clr wins over both handshakes, so neither side advances that cycle.
  assign in_fire  = io.in_valid  & io.in_ready  & ~sync_clr;
  assign out_fire = io.out_valid & io.out_ready & ~sync_clr;
  assign wr_done  = in_fire  & (wr_cnt == 4'd15);
  assign rd_done  = out_fire & (rd_cnt == 4'd15);

  assign we[0] = in_fire & ~wr_bank;
  assign we[1] = in_fire &  wr_bank;

  assign rd_idx = INVERSE ? AES_INV_SR_IDX[rd_cnt] : AES_FWD_SR_IDX[rd_cnt];

  aes_byte_bank u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we[0]),
    .waddr (wr_cnt),
    .wdata (io.in_data),
    .raddr (rd_idx),
    .rdata (rdata0)
  );

  aes_byte_bank u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we[1]),
    .waddr (wr_cnt),
    .wdata (io.in_data),
    .raddr (rd_idx),
    .rdata (rdata1)
  );

  assign rdata_sel   = rd_bank ? rdata1 : rdata0;
  assign io.out_data = io.out_valid ? rdata_sel : '0;
  assign io.out_last = io.out_valid & (rd_cnt == 4'd15);

  // Write and read always target different banks, so both updates can land.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else if (sync_clr) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      full    <= '0;
    end else begin
      if (in_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
      full <= full_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_shiftrows_stream.sv
// Self-checking bench for aes_inv_shiftrows_stream: spec vectors, random
// blocks against a row-rotation model, backpressure, abort, reset, round trip.
module tb_aes_inv_shiftrows_stream;
  import aes_pkg::*;

  typedef byte_t blk_t [16];
  typedef struct {
    int   sel;
    blk_t din;
    blk_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n;
  logic  clr [2];
  logic  rt_clr;
  logic  in_valid_d [2];
  byte_t in_data_d [2];
  logic  out_ready_d [2];
  logic  in_ready_s [2];
  logic  out_valid_s [2];
  byte_t out_data_s [2];
  logic  out_last_s [2];
  logic  rt_in_valid;
  byte_t rt_in_data;
  logic  rt_out_ready;

  int total = 0;
  int bad = 0;

  aes_inv_shiftrows_stream_if iv_if ();
  aes_inv_shiftrows_stream_if fv_if ();
  aes_inv_shiftrows_stream_if rf_if ();
  aes_inv_shiftrows_stream_if ri_if ();

  assign iv_if.in_valid  = in_valid_d[0];
  assign iv_if.in_data   = in_data_d[0];
  assign iv_if.out_ready = out_ready_d[0];
  assign fv_if.in_valid  = in_valid_d[1];
  assign fv_if.in_data   = in_data_d[1];
  assign fv_if.out_ready = out_ready_d[1];
  assign in_ready_s[0]  = iv_if.in_ready;
  assign out_valid_s[0] = iv_if.out_valid;
  assign out_data_s[0]  = iv_if.out_data;
  assign out_last_s[0]  = iv_if.out_last;
  assign in_ready_s[1]  = fv_if.in_ready;
  assign out_valid_s[1] = fv_if.out_valid;
  assign out_data_s[1]  = fv_if.out_data;
  assign out_last_s[1]  = fv_if.out_last;

  assign rf_if.in_valid  = rt_in_valid;
  assign rf_if.in_data   = rt_in_data;
  assign rf_if.out_ready = ri_if.in_ready;
  assign ri_if.in_valid  = rf_if.out_valid;
  assign ri_if.in_data   = rf_if.out_data;
  assign ri_if.out_ready = rt_out_ready;

  aes_inv_shiftrows_stream #(.INVERSE(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .sync_clr(clr[0]), .io(iv_if));
  aes_inv_shiftrows_stream #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .sync_clr(clr[1]), .io(fv_if));
  aes_inv_shiftrows_stream #(.INVERSE(1'b0)) u_rt_fwd (
    .clk(clk), .rst_n(rst_n), .sync_clr(rt_clr), .io(rf_if));
  aes_inv_shiftrows_stream #(.INVERSE(1'b1)) u_rt_inv (
    .clk(clk), .rst_n(rst_n), .sync_clr(rt_clr), .io(ri_if));

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] pack(input blk_t b);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[127 - 8*k -: 8] = b[k];
    return v;
  endfunction

  // State matrix view: byte k sits at row k%4, column k/4; each row is rotated.
  function automatic blk_t model(input bit inverse, input blk_t s);
    blk_t o;
    for (int k = 0; k < 16; k++) begin
      int r, c, sc;
      r  = k % 4;
      c  = k / 4;
      sc = inverse ? (c + 4 - r) % 4 : (c + r) % 4;
      o[k] = s[sc*4 + r];
    end
    return o;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < 16; k++) b[k] = byte_t'($urandom_range(0, 255));
    return b;
  endfunction

  // Feeds one block with out_ready high while collecting the permuted block.
  task automatic feed_and_collect(input int sel, input blk_t din, output blk_t dout,
                                  output int last_bad, output int lat);
    int n_in, n_out, cyc, fire_cyc;
    logic acc;
    n_in = 0; n_out = 0; cyc = 0; fire_cyc = -1000; last_bad = 0; lat = -1;
    dout = '{default: 8'h00};
    out_ready_d[sel] = 1'b1;
    while ((n_in < 16 || n_out < 16) && cyc < 200) begin
      if (out_valid_s[sel]) begin
        if (lat < 0) lat = cyc - fire_cyc;
        if (n_out < 16) dout[n_out] = out_data_s[sel];
        if (out_last_s[sel] != (n_out == 15)) last_bad++;
        n_out++;
      end
      in_valid_d[sel] = (n_in < 16);
      if (n_in < 16) in_data_d[sel] = din[n_in];
      acc = in_valid_d[sel] && in_ready_s[sel];
      @(posedge clk);
      if (acc) begin
        n_in++;
        if (n_in == 16) fire_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_d[sel] = 1'b0;
    if (n_in < 16 || n_out < 16) last_bad++;
  endtask

  task automatic feed_only(input int sel, input blk_t din, input int nbytes);
    int n_in, cyc;
    logic acc;
    n_in = 0; cyc = 0;
    while (n_in < nbytes && cyc < 100) begin
      in_valid_d[sel] = 1'b1;
      in_data_d[sel]  = din[n_in];
      acc = in_ready_s[sel];
      @(posedge clk);
      if (acc) n_in++;
      @(negedge clk);
      cyc++;
    end
    in_valid_d[sel] = 1'b0;
    chk("feed_only_accept", 128'(n_in), 128'(nbytes));
  endtask

  vec_t vecs [4];
  blk_t got_b, seq_b;
  int   last_bad, lat;

  initial begin
    byte_t q_got [$];
    byte_t rt_src [1600];
    int n_in, cyc, c16, c33, seen, drops;
    logic acc, ofire;

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      clr[s] = 1'b0; in_valid_d[s] = 1'b0; in_data_d[s] = 8'h00; out_ready_d[s] = 1'b0;
    end
    rt_clr = 1'b0; rt_in_valid = 1'b0; rt_in_data = 8'h00; rt_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++)
      chk("reset_outputs", {in_ready_s[s], out_valid_s[s], out_data_s[s], out_last_s[s]},
          {1'b1, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors: spec constants plus random blocks against the model.
    for (int k = 0; k < 16; k++) seq_b[k] = byte_t'(k);
    vecs[0].sel = 0; vecs[0].din = seq_b;
    vecs[0].exp = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                    8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    vecs[1].sel = 1; vecs[1].din = seq_b;
    vecs[1].exp = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                    8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    vecs[2].sel = 0; vecs[2].din = rand_blk(); vecs[2].exp = model(1'b1, vecs[2].din);
    vecs[3].sel = 1; vecs[3].din = rand_blk(); vecs[3].exp = model(1'b0, vecs[3].din);
    for (int v = 0; v < 4; v++) begin
      feed_and_collect(vecs[v].sel, vecs[v].din, got_b, last_bad, lat);
      chk($sformatf("vec%0d_data", v), pack(got_b), pack(vecs[v].exp));
      chk($sformatf("vec%0d_last", v), 128'(last_bad), 128'd0);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'd1);
    end
    for (int v = 0; v < 6; v++) begin
      blk_t rb;
      rb = rand_blk();
      feed_and_collect(v % 2, rb, got_b, last_bad, lat);
      chk($sformatf("rand%0d_data", v), pack(got_b), pack(model(v % 2 == 0, rb)));
    end

    // Backpressure: out_ready low, offer 40 bytes.
    out_ready_d[0] = 1'b0;
    n_in = 0;
    for (int c = 0; c < 45; c++) begin
      in_valid_d[0] = (n_in < 40);
      in_data_d[0]  = byte_t'(n_in);
      acc = in_valid_d[0] && in_ready_s[0];
      @(posedge clk);
      if (acc) n_in++;
      @(negedge clk);
    end
    chk("bp_accepted", 128'(n_in), 128'd32);
    chk("bp_in_ready", 128'(in_ready_s[0]), 128'd0);
    q_got.delete();
    cyc = 0; c16 = -1; c33 = -100;
    while ((q_got.size() < 32 || n_in < 40) && cyc < 300) begin
      out_ready_d[0] = 1'b1;
      ofire = out_valid_s[0];
      if (ofire) q_got.push_back(out_data_s[0]);
      in_valid_d[0] = (n_in < 40);
      in_data_d[0]  = byte_t'(n_in);
      acc = in_valid_d[0] && in_ready_s[0];
      @(posedge clk);
      if (ofire && q_got.size() == 16) c16 = cyc;
      if (acc && n_in == 32) c33 = cyc;
      if (acc) n_in++;
      @(negedge clk);
      cyc++;
    end
    in_valid_d[0] = 1'b0;
    chk("bp_33rd_timing", 128'(c33), 128'(c16 + 1));
    chk("bp_out_count", 128'(q_got.size()), 128'd32);
    for (int b = 0; b < 2; b++) begin
      blk_t ib, ob;
      for (int k = 0; k < 16; k++) begin
        ib[k] = byte_t'(b*16 + k);
        ob[k] = (q_got.size() > b*16 + k) ? q_got[b*16 + k] : 8'h00;
      end
      chk($sformatf("bp_block%0d", b), pack(ob), pack(model(1'b1, ib)));
    end
    repeat (5) @(negedge clk);
    chk("bp_partial_held", 128'(out_valid_s[0]), 128'd0);

    // Abort: partial blocks dropped, then a clean block follows.
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    for (int k = 0; k < 16; k++) seq_b[k] = byte_t'(8'hA0 + k);
    feed_only(0, seq_b, 7);
    chk("clr_no_output", 128'(out_valid_s[0]), 128'd0);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    for (int k = 0; k < 16; k++) seq_b[k] = byte_t'(8'h10 + k);
    feed_and_collect(0, seq_b, got_b, last_bad, lat);
    chk("clr_block", pack(got_b), pack(model(1'b1, seq_b)));
    chk("clr_head", {got_b[0], got_b[1], got_b[2], got_b[3]}, 32'h101D1A17);
    chk("clr_latency", 128'(lat), 128'd1);

    // Reset asserted after the first output byte of a block.
    out_ready_d[0] = 1'b0;
    seq_b = rand_blk();
    feed_only(0, seq_b, 16);
    chk("rst_pre_valid", 128'(out_valid_s[0]), 128'd1);
    out_ready_d[0] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {in_ready_s[0], out_valid_s[0], out_data_s[0], out_last_s[0]},
        {1'b1, 1'b0, 8'h00, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid_s[0]) seen++;
    end
    chk("rst_no_residual", 128'(seen), 128'd0);
    seq_b = rand_blk();
    feed_and_collect(0, seq_b, got_b, last_bad, lat);
    chk("rst_fresh_block", pack(got_b), pack(model(1'b1, seq_b)));

    // Round trip: forward then inverse, 100 random blocks at full rate.
    for (int i = 0; i < 1600; i++) rt_src[i] = byte_t'($urandom_range(0, 255));
    q_got.delete();
    n_in = 0; cyc = 0; drops = 0;
    while (q_got.size() < 1600 && cyc < 2000) begin
      if (ri_if.out_valid) q_got.push_back(ri_if.out_data);
      rt_in_valid = (n_in < 1600);
      if (n_in < 1600) rt_in_data = rt_src[n_in];
      if (rt_in_valid && !rf_if.in_ready) drops++;
      acc = rt_in_valid && rf_if.in_ready;
      @(posedge clk);
      if (acc) n_in++;
      @(negedge clk);
      cyc++;
    end
    rt_in_valid = 1'b0;
    chk("rt_ready_drops", 128'(drops), 128'd0);
    chk("rt_count", 128'(q_got.size()), 128'd1600);
    chk("rt_rate", 128'(cyc <= 1640), 128'd1);
    for (int b = 0; b < 100; b++) begin
      blk_t ib, ob;
      for (int k = 0; k < 16; k++) begin
        ib[k] = rt_src[b*16 + k];
        ob[k] = (q_got.size() > b*16 + k) ? q_got[b*16 + k] : 8'h00;
      end
      chk($sformatf("rt_block%0d", b), pack(ob), pack(ib));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_shiftrows_stream.md
# aes_inv_shiftrows_stream

Byte-serial, double-buffered InvShiftRows stage for the AES-128 decryption datapath. It accepts a 16-byte state as a byte stream in column-major order and emits the InvShiftRows-permuted state as a byte stream. The design sustains one byte per cycle with ping-pong banks. It sits between the byte-wide key-addition stage and the inverse S-box stage. A parameter selects forward ShiftRows so the same block can serve the encryption path.

## Interface
- INVERSE, 1, 1 = InvShiftRows (row r rotated right by r); 0 = forward ShiftRows (row r rotated left by r)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sync_clr  in  1  synchronous abort: drop all buffered and partial blocks
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept an input byte
- in_data  in  8  input byte; byte k of block is state byte s_k (s0 = bits 127:120 of the 128-bit state)
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts output byte
- out_data  out  8  output byte o_k
- out_last  out  1  high with the 16th output byte of a block

## Operation
- Input byte transfers when in_valid && in_ready. Output byte transfers when out_valid && out_ready.
- Storage is two banks of 16×8 registers plus a full flag per bank.
- Write side: wr_bank (1 b) and wr_cnt (4 b).
  - Each accepted byte is written to bank[wr_bank][wr_cnt], then wr_cnt increments.
  - On accepting wr_cnt == 15: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- in_ready = !full[wr_bank]. It is registered-flag based and has no combinational path from out_ready.
- Read side: rd_bank and rd_cnt.
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][P(rd_cnt)]. When out_valid is 0, out_data is forced to 0x00.
  - On accepting rd_cnt == 15: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0.
- Permutation P, output index k → source index:
  - INVERSE=1: 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
  - INVERSE=0: 0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11.
- out_last = out_valid && rd_cnt == 15.
- A block is never emitted until all 16 of its bytes are buffered. Partial blocks are held indefinitely.
- Simultaneous events:
  - Write completing into one bank and read completing from the other in the same cycle: both flag updates take effect.
  - A bank freed at edge N is writable in cycle N+1. There is no same-cycle bypass.
- sync_clr has priority over all handshakes in that cycle. The next edge clears wr_cnt, rd_cnt, wr_bank, rd_bank and both full flags. Bank contents are not cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0x00, out_last=0. All counters, bank selects and full flags are 0. Bank registers are reset to 0.
- Latency: 16th input byte accepted at edge N → first output byte valid in cycle N+1 (the cycle after that edge).
- Throughput: with in_valid and out_ready held high, in_ready never drops. Sustained rate is 1 byte/cycle in and out.
- Backpressure: with out_ready low, at most 32 bytes are accepted, then in_ready=0 until the read side frees a bank.
- Reset asserted mid-block: all state returns to reset values immediately. There is no output until a fresh 16 bytes arrive.

## Structure
- Shared package aes_pkg holds:
  - AES_BLK_BYTES = 16
  - the constant index arrays AES_INV_SR_IDX and AES_FWD_SR_IDX (16 × 4 b)
  - a byte_t typedef
- One sub-module, aes_byte_bank: a 16×8 register bank with write enable, 4-bit write address and 4-bit combinational read address. It is instantiated twice.

## Test plan
- INVERSE=1, bytes 0x00..0x0F, out_ready=1 → out 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. out_last only on 0x03. First out_valid in the cycle after the 16th input edge.
- INVERSE=0, same input → out 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
- Round trip: a forward instance chained into an inverse instance, 100 random blocks → output equals input. Throughput is 1 byte/cycle with no in_ready deassertion.
- out_ready=0, drive 40 bytes → exactly 32 accepted and in_ready=0. Then release out_ready → blocks emerge in order, and the 33rd byte is accepted one cycle after the first bank empties.
- Feed 7 bytes, pulse sync_clr, then feed 0x10..0x1F → only the permuted 0x10..0x1F block is emitted (INVERSE=1: 10 1D 1A 17 …).
- Assert rst_n low after the first output byte of a block → out_valid=0 and in_ready=1 immediately. No residual bytes after rst_n is released.
